// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: next-PC select codes, opcode/funct values,
// reset PC and the fetch FSM state type.
package mips_pkg;

   localparam logic [2:0] NPC_PC4 = 3'b000;
   localparam logic [2:0] NPC_BEQ = 3'b001;
   localparam logic [2:0] NPC_JAL = 3'b010;
   localparam logic [2:0] NPC_J   = 3'b011;
   localparam logic [2:0] NPC_JR  = 3'b100;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   localparam logic [5:0] FUNCT_JR   = 6'h08;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } ifu_state_t;

endpackage

// File: rtl/npc.sv
// Combinational next-PC calculator: zero latency, no handshake.
// Flags a misaligned result (only reachable through JR).
module npc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [25:0] instr_idx,
   input  logic [2:0]  npc_sel,
   input  logic        zero,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] pc4;
   logic [31:0] br_off;

   assign pc4    = pc + 32'd4;
   assign br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};

   always_comb begin
      next_pc = pc4;
      case (npc_sel)
         NPC_BEQ:        if (zero) next_pc = pc4 + br_off;
         NPC_JAL, NPC_J: next_pc = {pc4[31:28], instr_idx, 2'b00};
         NPC_JR:         next_pc = jr_target;
         default:        next_pc = pc4;
      endcase
   end

   assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: FETCH holds req/addr until imem_rdy, EXEC holds pc/instr until commit.
// Zero-wait loop is 2 cycles per instruction; a misaligned target halts until reset.
module ifu
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  npc_sel,
   input  logic        zero,
   input  logic [31:0] jr_target,
   input  logic        commit,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        fault
);

   ifu_state_t  state;
   ifu_state_t  state_nxt;
   logic [31:0] next_pc;
   logic        misaligned;

   npc u_npc (
      .pc         (pc),
      .instr_idx  (instr[25:0]),
      .npc_sel    (npc_sel),
      .zero       (zero),
      .jr_target  (jr_target),
      .next_pc    (next_pc),
      .misaligned (misaligned)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_RST;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RST:   state_nxt = ST_FETCH;
         ST_FETCH: if (imem_rdy) state_nxt = ST_EXEC;
         ST_EXEC:  if (commit) state_nxt = misaligned ? ST_HALT : ST_FETCH;
         ST_HALT:  state_nxt = ST_HALT;
         default:  state_nxt = ST_RST;
      endcase
   end

   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      fault       = 1'b0;
      case (state)
         ST_FETCH: imem_req    = 1'b1;
         ST_EXEC:  instr_valid = 1'b1;
         ST_HALT:  fault       = 1'b1;
         default:  ;
      endcase
   end

   // pc only moves on a clean commit, so imem_addr is frozen for all of FETCH
   always_ff @(posedge clk) begin
      if (reset) begin
         pc    <= RESET_PC;
         instr <= '0;
      end else begin
         if (state == ST_FETCH && imem_rdy)
            instr <= imem_rdata;
         if (state == ST_EXEC && commit && !misaligned)
            pc <= next_pc;
      end
   end

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;

endmodule

// File: tb/tb_ifu.sv
// Randomized bench for ifu against a transaction-level model of fetch/commit.
module tb_ifu;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  npc_sel;
   logic        zero;
   logic [31:0] jr_target;
   logic        commit;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        fault;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_pc;
   logic [31:0] exp_instr;
   logic        halted;

   ifu dut (
      .clk         (clk),
      .reset       (reset),
      .npc_sel     (npc_sel),
      .zero        (zero),
      .jr_target   (jr_target),
      .commit      (commit),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdy    (imem_rdy),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural next-PC rule written as plain arithmetic.
   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] iw,
                                              input logic [2:0] sel, input logic z,
                                              input logic [31:0] jr);
      int off;
      off = $signed(iw[15:0]);
      case (sel)
         3'd1:       return z ? cur + 32'd4 + 32'(off * 4) : cur + 32'd4;
         3'd2, 3'd3: return ((cur + 32'd4) & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 32'd4);
         3'd4:       return jr;
         default:    return cur + 32'd4;
      endcase
   endfunction

   task automatic do_reset();
      reset      = 1'b1;
      commit     = $urandom_range(0, 1);
      imem_rdy   = $urandom_range(0, 1);
      imem_rdata = $urandom;
      tick();
      chk("rst_pc", pc, 32'h3000);
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      reset  = 1'b0;
      commit = 1'b0;
      tick();
      exp_pc    = 32'h3000;
      exp_instr = 32'h0;
      halted    = 1'b0;
      chk("post_rst_req", {31'b0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, 32'h3000);
   endtask

   // Entered in FETCH; leaves the DUT in EXEC.
   task automatic fetch(input logic [31:0] word, input int waits);
      for (int i = 0; i <= waits; i++) begin
         chk("fetch_req", {31'b0, imem_req}, 32'd1);
         chk("fetch_addr", imem_addr, exp_pc);
         chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
         commit     = $urandom_range(0, 1);
         imem_rdy   = (i == waits);
         imem_rdata = (i == waits) ? word : $urandom;
         tick();
      end
      imem_rdy  = 1'b0;
      commit    = 1'b0;
      exp_instr = word;
      chk("exec_valid", {31'b0, instr_valid}, 32'd1);
      chk("exec_req", {31'b0, imem_req}, 32'd0);
      chk("exec_instr", instr, exp_instr);
      chk("exec_pc", pc, exp_pc);
      chk("exec_pc4", pc_plus4, exp_pc + 32'd4);
   endtask

   // Entered in EXEC; leaves the DUT in FETCH, or halted on a misaligned target.
   task automatic exec(input logic [2:0] sel, input logic z, input logic [31:0] jr, input int stalls);
      logic [31:0] nxt;
      for (int i = 0; i < stalls; i++) begin
         commit     = 1'b0;
         imem_rdy   = $urandom_range(0, 1);
         imem_rdata = $urandom;
         npc_sel    = 3'($urandom);
         tick();
         chk("stall_valid", {31'b0, instr_valid}, 32'd1);
         chk("stall_instr", instr, exp_instr);
         chk("stall_pc", pc, exp_pc);
      end
      imem_rdy  = $urandom_range(0, 1);
      npc_sel   = sel;
      zero      = z;
      jr_target = jr;
      commit    = 1'b1;
      nxt = model_next(exp_pc, exp_instr, sel, z, jr);
      tick();
      commit   = 1'b0;
      imem_rdy = 1'b0;
      if (nxt[1:0] != 2'b00) begin
         halted = 1'b1;
         for (int i = 0; i < 4; i++) begin
            chk("halt_fault", {31'b0, fault}, 32'd1);
            chk("halt_req", {31'b0, imem_req}, 32'd0);
            chk("halt_pc", pc, exp_pc);
            commit   = $urandom_range(0, 1);
            imem_rdy = $urandom_range(0, 1);
            tick();
         end
         commit   = 1'b0;
         imem_rdy = 1'b0;
      end else begin
         exp_pc = nxt;
         chk("commit_pc", pc, exp_pc);
         chk("commit_req", {31'b0, imem_req}, 32'd1);
         chk("commit_valid", {31'b0, instr_valid}, 32'd0);
         chk("commit_fault", {31'b0, fault}, 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1; npc_sel = 3'd0; zero = 1'b0; jr_target = 32'h0;
      commit = 1'b0; imem_rdy = 1'b0; imem_rdata = 32'h0;
      halted = 1'b0; exp_pc = 32'h3000; exp_instr = 32'h0;

      // directed scenarios
      do_reset();
      fetch(32'h3408_0001, 0);
      exec(3'd0, 1'b0, 32'h0, 0);
      chk("ori_next_pc", pc, 32'h3004);
      fetch(32'h3409_0002, 3);
      exec(3'd0, 1'b0, 32'h0, 2);
      chk("seq_pc", pc, 32'h3008);
      fetch(32'h1000_FFFE, 1);
      exec(3'd1, 1'b1, 32'h0, 1);
      chk("beq_taken", pc, 32'h3004);
      fetch(32'h3408_0001, 0);
      exec(3'd0, 1'b0, 32'h0, 0);
      fetch(32'h1000_FFFE, 0);
      exec(3'd1, 1'b0, 32'h0, 0);
      chk("beq_not_taken", pc, 32'h300C);
      fetch(32'h0, 0);
      exec(3'd0, 1'b0, 32'h0, 0);
      fetch(32'h0C00_0C10, 2);
      chk("jal_link", pc_plus4, 32'h3014);
      exec(3'd2, 1'b0, 32'h0, 1);
      chk("jal_target", pc, 32'h0000_3040);
      fetch(32'h0100_0008, 0);
      exec(3'd4, 1'b0, 32'h3002, 0);
      chk("jr_fault", {31'b0, fault}, 32'd1);
      chk("jr_pc_held", pc, 32'h3040);
      do_reset();

      // reset wins over a same-cycle memory response mid-FETCH
      imem_rdy = 1'b1; imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
      tick();
      chk("midfetch_valid", {31'b0, instr_valid}, 32'd0);
      chk("midfetch_pc", pc, 32'h3000);
      chk("midfetch_instr", instr, 32'h0);
      do_reset();

      // randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         logic [2:0]  sel;
         logic [31:0] jr;
         sel = 3'($urandom);
         jr  = $urandom;
         if ($urandom_range(0, 9) != 0) jr[1:0] = 2'b00;
         fetch($urandom, $urandom_range(0, 3));
         exec(sel, 1'($urandom), jr, $urandom_range(0, 2));
         if (halted) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
